// File: rtl/rs_alu_scheduler.sv
// Reservation station for the single ALU: buffers issued ops, wakes pending operands from the
// ALU/LSB result broadcasts and dispatches the lowest-index ready entry each cycle.
module rs_alu_scheduler #(
    parameter int RS_SIZE   = 16,
    parameter int ROB_POS_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 rollback,
    input  logic                 issue_valid,
    input  logic [6:0]           issue_opcode,
    input  logic [2:0]           issue_funct3,
    input  logic                 issue_funct7,
    input  logic [31:0]          issue_val1,
    input  logic [31:0]          issue_val2,
    input  logic                 issue_pend1,
    input  logic                 issue_pend2,
    input  logic [ROB_POS_W-1:0] issue_tag1,
    input  logic [ROB_POS_W-1:0] issue_tag2,
    input  logic [31:0]          issue_imm,
    input  logic [31:0]          issue_pc,
    input  logic [ROB_POS_W-1:0] issue_rob_pos,
    output logic                 rs_full,
    input  logic                 alu_res,
    input  logic [ROB_POS_W-1:0] alu_res_rob_pos,
    input  logic [31:0]          alu_res_val,
    input  logic                 lsb_res,
    input  logic [ROB_POS_W-1:0] lsb_res_rob_pos,
    input  logic [31:0]          lsb_res_val,
    output logic                 alu_en,
    output logic [6:0]           alu_opcode,
    output logic [2:0]           alu_funct3,
    output logic                 alu_funct7,
    output logic [31:0]          alu_val1,
    output logic [31:0]          alu_val2,
    output logic [31:0]          alu_imm,
    output logic [31:0]          alu_pc,
    output logic [ROB_POS_W-1:0] alu_rob_pos
);
    localparam int IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0]   busy_q, busy_d;
    logic [RS_SIZE-1:0]   pend1_q, pend1_d;
    logic [RS_SIZE-1:0]   pend2_q, pend2_d;
    logic [31:0]          val1_q [RS_SIZE];
    logic [31:0]          val1_d [RS_SIZE];
    logic [31:0]          val2_q [RS_SIZE];
    logic [31:0]          val2_d [RS_SIZE];
    logic [ROB_POS_W-1:0] tag1_q [RS_SIZE];
    logic [ROB_POS_W-1:0] tag2_q [RS_SIZE];
    logic [6:0]           opcode_q [RS_SIZE];
    logic [2:0]           funct3_q [RS_SIZE];
    logic                 funct7_q [RS_SIZE];
    logic [31:0]          imm_q [RS_SIZE];
    logic [31:0]          pc_q [RS_SIZE];
    logic [ROB_POS_W-1:0] rob_pos_q [RS_SIZE];

    logic                 alu_en_q, alu_en_d;
    logic [6:0]           alu_opcode_q, alu_opcode_d;
    logic [2:0]           alu_funct3_q, alu_funct3_d;
    logic                 alu_funct7_q, alu_funct7_d;
    logic [31:0]          alu_val1_q, alu_val1_d;
    logic [31:0]          alu_val2_q, alu_val2_d;
    logic [31:0]          alu_imm_q, alu_imm_d;
    logic [31:0]          alu_pc_q, alu_pc_d;
    logic [ROB_POS_W-1:0] alu_rob_pos_q, alu_rob_pos_d;

    logic [RS_SIZE-1:0]   ready;
    logic                 disp_found;
    logic [IDX_W-1:0]     disp_idx;
    logic [IDX_W-1:0]     free_idx;
    logic                 issue_we;
    logic                 iss_pend1, iss_pend2;
    logic [31:0]          iss_val1, iss_val2;

    assign rs_full  = &busy_q;
    assign issue_we = rdy && !rollback && issue_valid && !rs_full;

    // Descending scan so the lowest matching index is the last one assigned.
    always_comb begin
        ready      = busy_q & ~pend1_q & ~pend2_q;
        disp_found = 1'b0;
        disp_idx   = '0;
        free_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) begin
                disp_found = 1'b1;
                disp_idx   = IDX_W'(i);
            end
            if (!busy_q[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    // Same-cycle broadcast forwarding into the newly written entry; ALU wins over LSB.
    always_comb begin
        iss_pend1 = issue_pend1;
        iss_val1  = issue_val1;
        iss_pend2 = issue_pend2;
        iss_val2  = issue_val2;
        if (issue_pend1) begin
            if (alu_res && alu_res_rob_pos == issue_tag1) begin
                iss_pend1 = 1'b0;
                iss_val1  = alu_res_val;
            end else if (lsb_res && lsb_res_rob_pos == issue_tag1) begin
                iss_pend1 = 1'b0;
                iss_val1  = lsb_res_val;
            end
        end
        if (issue_pend2) begin
            if (alu_res && alu_res_rob_pos == issue_tag2) begin
                iss_pend2 = 1'b0;
                iss_val2  = alu_res_val;
            end else if (lsb_res && lsb_res_rob_pos == issue_tag2) begin
                iss_pend2 = 1'b0;
                iss_val2  = lsb_res_val;
            end
        end
    end

    always_comb begin
        busy_d        = busy_q;
        pend1_d       = pend1_q;
        pend2_d       = pend2_q;
        val1_d        = val1_q;
        val2_d        = val2_q;
        alu_en_d      = alu_en_q;
        alu_opcode_d  = alu_opcode_q;
        alu_funct3_d  = alu_funct3_q;
        alu_funct7_d  = alu_funct7_q;
        alu_val1_d    = alu_val1_q;
        alu_val2_d    = alu_val2_q;
        alu_imm_d     = alu_imm_q;
        alu_pc_d      = alu_pc_q;
        alu_rob_pos_d = alu_rob_pos_q;
        if (rollback) begin
            busy_d        = '0;
            alu_en_d      = 1'b0;
            alu_opcode_d  = '0;
            alu_funct3_d  = '0;
            alu_funct7_d  = 1'b0;
            alu_val1_d    = '0;
            alu_val2_d    = '0;
            alu_imm_d     = '0;
            alu_pc_d      = '0;
            alu_rob_pos_d = '0;
        end else if (rdy) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_q[i] && pend1_q[i]) begin
                    if (alu_res && alu_res_rob_pos == tag1_q[i]) begin
                        val1_d[i]  = alu_res_val;
                        pend1_d[i] = 1'b0;
                    end else if (lsb_res && lsb_res_rob_pos == tag1_q[i]) begin
                        val1_d[i]  = lsb_res_val;
                        pend1_d[i] = 1'b0;
                    end
                end
                if (busy_q[i] && pend2_q[i]) begin
                    if (alu_res && alu_res_rob_pos == tag2_q[i]) begin
                        val2_d[i]  = alu_res_val;
                        pend2_d[i] = 1'b0;
                    end else if (lsb_res && lsb_res_rob_pos == tag2_q[i]) begin
                        val2_d[i]  = lsb_res_val;
                        pend2_d[i] = 1'b0;
                    end
                end
            end
            alu_en_d = disp_found;
            if (disp_found) begin
                busy_d[disp_idx] = 1'b0;
                alu_opcode_d     = opcode_q[disp_idx];
                alu_funct3_d     = funct3_q[disp_idx];
                alu_funct7_d     = funct7_q[disp_idx];
                alu_val1_d       = val1_q[disp_idx];
                alu_val2_d       = val2_q[disp_idx];
                alu_imm_d        = imm_q[disp_idx];
                alu_pc_d         = pc_q[disp_idx];
                alu_rob_pos_d    = rob_pos_q[disp_idx];
            end
            // free_idx was busy=0 before the edge, so it never collides with disp_idx.
            if (issue_we) begin
                busy_d[free_idx]  = 1'b1;
                pend1_d[free_idx] = iss_pend1;
                pend2_d[free_idx] = iss_pend2;
                val1_d[free_idx]  = iss_val1;
                val2_d[free_idx]  = iss_val2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q        <= '0;
            alu_en_q      <= 1'b0;
            alu_opcode_q  <= '0;
            alu_funct3_q  <= '0;
            alu_funct7_q  <= 1'b0;
            alu_val1_q    <= '0;
            alu_val2_q    <= '0;
            alu_imm_q     <= '0;
            alu_pc_q      <= '0;
            alu_rob_pos_q <= '0;
        end else begin
            busy_q        <= busy_d;
            pend1_q       <= pend1_d;
            pend2_q       <= pend2_d;
            val1_q        <= val1_d;
            val2_q        <= val2_d;
            alu_en_q      <= alu_en_d;
            alu_opcode_q  <= alu_opcode_d;
            alu_funct3_q  <= alu_funct3_d;
            alu_funct7_q  <= alu_funct7_d;
            alu_val1_q    <= alu_val1_d;
            alu_val2_q    <= alu_val2_d;
            alu_imm_q     <= alu_imm_d;
            alu_pc_q      <= alu_pc_d;
            alu_rob_pos_q <= alu_rob_pos_d;
            if (issue_we) begin
                tag1_q[free_idx]    <= issue_tag1;
                tag2_q[free_idx]    <= issue_tag2;
                opcode_q[free_idx]  <= issue_opcode;
                funct3_q[free_idx]  <= issue_funct3;
                funct7_q[free_idx]  <= issue_funct7;
                imm_q[free_idx]     <= issue_imm;
                pc_q[free_idx]      <= issue_pc;
                rob_pos_q[free_idx] <= issue_rob_pos;
            end
        end
    end

    assign alu_en      = alu_en_q;
    assign alu_opcode  = alu_opcode_q;
    assign alu_funct3  = alu_funct3_q;
    assign alu_funct7  = alu_funct7_q;
    assign alu_val1    = alu_val1_q;
    assign alu_val2    = alu_val2_q;
    assign alu_imm     = alu_imm_q;
    assign alu_pc      = alu_pc_q;
    assign alu_rob_pos = alu_rob_pos_q;

endmodule

// File: tb/tb_rs_alu_scheduler.sv
// Bench for rs_alu_scheduler: directed vector table, multi-cycle corner sequences and
// randomized traffic checked against an entry-list reference model.
module tb_rs_alu_scheduler;
    localparam int N = 16;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rdy, rollback, issue_valid;
    logic [6:0]  issue_opcode;
    logic [2:0]  issue_funct3;
    logic        issue_funct7;
    logic [31:0] issue_val1, issue_val2, issue_imm, issue_pc;
    logic        issue_pend1, issue_pend2;
    logic [3:0]  issue_tag1, issue_tag2, issue_rob_pos;
    logic        rs_full;
    logic        alu_res, lsb_res;
    logic [3:0]  alu_res_rob_pos, lsb_res_rob_pos;
    logic [31:0] alu_res_val, lsb_res_val;
    logic        alu_en;
    logic [6:0]  alu_opcode;
    logic [2:0]  alu_funct3;
    logic        alu_funct7;
    logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
    logic [3:0]  alu_rob_pos;

    rs_alu_scheduler #(.RS_SIZE(N), .ROB_POS_W(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .issue_valid(issue_valid), .issue_opcode(issue_opcode), .issue_funct3(issue_funct3),
        .issue_funct7(issue_funct7), .issue_val1(issue_val1), .issue_val2(issue_val2),
        .issue_pend1(issue_pend1), .issue_pend2(issue_pend2), .issue_tag1(issue_tag1),
        .issue_tag2(issue_tag2), .issue_imm(issue_imm), .issue_pc(issue_pc),
        .issue_rob_pos(issue_rob_pos), .rs_full(rs_full),
        .alu_res(alu_res), .alu_res_rob_pos(alu_res_rob_pos), .alu_res_val(alu_res_val),
        .lsb_res(lsb_res), .lsb_res_rob_pos(lsb_res_rob_pos), .lsb_res_val(lsb_res_val),
        .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_funct3(alu_funct3),
        .alu_funct7(alu_funct7), .alu_val1(alu_val1), .alu_val2(alu_val2),
        .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rob_pos(alu_rob_pos)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: list of held ops plus the last dispatched op.
    typedef struct {
        logic        busy;
        logic        p1, p2;
        logic [3:0]  t1, t2, rob;
        logic [31:0] v1, v2, imm, pc;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
    } ent_t;
    ent_t m_ent[N];
    ent_t m_out;
    logic m_en;

    typedef struct {
        int rst, iv, p1, t1, v1, p2, t2, v2;
        int ar, at, av, lr, lt, lv;
        int e_en, e_v1, e_v2, e_full;
    } vec_t;
    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < N; i++) if (m_ent[i].busy) c++;
        return c;
    endfunction

    task automatic model_update();
        int d, f;
        ent_t e;
        if (rst || rollback) begin
            for (int i = 0; i < N; i++) m_ent[i].busy = 1'b0;
            m_en  = 1'b0;
            m_out = '{default: '0};
            return;
        end
        if (!rdy) return;
        d = -1;
        f = -1;
        for (int i = 0; i < N; i++) begin
            if (d < 0 && m_ent[i].busy && !m_ent[i].p1 && !m_ent[i].p2) d = i;
            if (f < 0 && !m_ent[i].busy) f = i;
        end
        for (int i = 0; i < N; i++) begin
            if (!m_ent[i].busy) continue;
            if (m_ent[i].p1 && alu_res && alu_res_rob_pos == m_ent[i].t1) begin
                m_ent[i].p1 = 1'b0; m_ent[i].v1 = alu_res_val;
            end else if (m_ent[i].p1 && lsb_res && lsb_res_rob_pos == m_ent[i].t1) begin
                m_ent[i].p1 = 1'b0; m_ent[i].v1 = lsb_res_val;
            end
            if (m_ent[i].p2 && alu_res && alu_res_rob_pos == m_ent[i].t2) begin
                m_ent[i].p2 = 1'b0; m_ent[i].v2 = alu_res_val;
            end else if (m_ent[i].p2 && lsb_res && lsb_res_rob_pos == m_ent[i].t2) begin
                m_ent[i].p2 = 1'b0; m_ent[i].v2 = lsb_res_val;
            end
        end
        m_en = (d >= 0);
        if (d >= 0) begin
            m_out = m_ent[d];
            m_ent[d].busy = 1'b0;
        end
        if (issue_valid && f >= 0) begin
            e.busy = 1'b1;
            e.p1 = issue_pend1; e.t1 = issue_tag1; e.v1 = issue_val1;
            e.p2 = issue_pend2; e.t2 = issue_tag2; e.v2 = issue_val2;
            if (e.p1 && alu_res && alu_res_rob_pos == e.t1) begin e.p1 = 1'b0; e.v1 = alu_res_val; end
            else if (e.p1 && lsb_res && lsb_res_rob_pos == e.t1) begin e.p1 = 1'b0; e.v1 = lsb_res_val; end
            if (e.p2 && alu_res && alu_res_rob_pos == e.t2) begin e.p2 = 1'b0; e.v2 = alu_res_val; end
            else if (e.p2 && lsb_res && lsb_res_rob_pos == e.t2) begin e.p2 = 1'b0; e.v2 = lsb_res_val; end
            e.rob = issue_rob_pos; e.imm = issue_imm; e.pc = issue_pc;
            e.op = issue_opcode; e.f3 = issue_funct3; e.f7 = issue_funct7;
            m_ent[f] = e;
        end
    endtask

    // One clock: advance the model on the inputs now applied, then compare after the edge.
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        check("alu_en", 32'(alu_en), 32'(m_en));
        check("rs_full", 32'(rs_full), 32'(model_count() == N));
        check("alu_opcode", 32'(alu_opcode), 32'(m_out.op));
        check("alu_funct3", 32'(alu_funct3), 32'(m_out.f3));
        check("alu_funct7", 32'(alu_funct7), 32'(m_out.f7));
        check("alu_val1", alu_val1, m_out.v1);
        check("alu_val2", alu_val2, m_out.v2);
        check("alu_imm", alu_imm, m_out.imm);
        check("alu_pc", alu_pc, m_out.pc);
        check("alu_rob_pos", 32'(alu_rob_pos), 32'(m_out.rob));
    endtask

    task automatic idle();
        rst = 1'b0; rollback = 1'b0; rdy = 1'b1;
        issue_valid = 1'b0; issue_pend1 = 1'b0; issue_pend2 = 1'b0;
        alu_res = 1'b0; lsb_res = 1'b0;
    endtask

    task automatic set_issue(input logic p1, input logic [3:0] t1, input logic [31:0] v1,
                             input logic p2, input logic [3:0] t2, input logic [31:0] v2,
                             input logic [3:0] rob);
        issue_valid = 1'b1;
        issue_opcode = 7'b0110011; issue_funct3 = 3'(rob); issue_funct7 = rob[0];
        issue_pend1 = p1; issue_tag1 = t1; issue_val1 = v1;
        issue_pend2 = p2; issue_tag2 = t2; issue_val2 = v2;
        issue_rob_pos = rob; issue_imm = {28'h0, rob} << 2; issue_pc = 32'h1000 + ({28'h0, rob} << 2);
    endtask

    initial begin
        for (int i = 0; i < N; i++) m_ent[i] = '{default: '0};
        m_out = '{default: '0};
        m_en = 1'b0;
        idle();
        rst = 1'b1;
        issue_tag1 = '0; issue_tag2 = '0; issue_val1 = '0; issue_val2 = '0;
        issue_opcode = '0; issue_funct3 = '0; issue_funct7 = 1'b0;
        issue_imm = '0; issue_pc = '0; issue_rob_pos = '0;
        alu_res_rob_pos = '0; alu_res_val = '0; lsb_res_rob_pos = '0; lsb_res_val = '0;

        //        rst iv p1 t1 v1 p2 t2 v2   ar at av     lr lt lv     en v1     v2     full
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,     0, 0, 0,     0, 0,     0,     0};
        tbl[1]  = '{0, 1, 0, 0, 5, 0, 0, 7,   0, 0, 0,     0, 0, 0,     0, 0,     0,     0};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,     0, 0, 0,     1, 5,     7,     0};
        tbl[3]  = '{0, 1, 1, 3, 0, 0, 0, 2,   0, 0, 0,     0, 0, 0,     0, 5,     7,     0};
        tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,     0, 0, 0,     0, 5,     7,     0};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,     0, 0, 0,     0, 5,     7,     0};
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 0,   1, 3, 'h10,  0, 0, 0,     0, 5,     7,     0};
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,     0, 0, 0,     1, 'h10,  2,     0};
        tbl[8]  = '{0, 1, 0, 0, 1, 1, 9, 0,   0, 0, 0,     1, 9, 'hAB,  0, 'h10,  2,     0};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,     0, 0, 0,     1, 1,     'hAB,  0};
        tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,     0, 0, 0,     0, 1,     'hAB,  0};

        for (int k = 0; k < 11; k++) begin
            idle();
            rst = tbl[k].rst != 0;
            if (tbl[k].iv != 0)
                set_issue(tbl[k].p1 != 0, 4'(tbl[k].t1), 32'(tbl[k].v1),
                          tbl[k].p2 != 0, 4'(tbl[k].t2), 32'(tbl[k].v2), 4'(k));
            alu_res = tbl[k].ar != 0; alu_res_rob_pos = 4'(tbl[k].at); alu_res_val = 32'(tbl[k].av);
            lsb_res = tbl[k].lr != 0; lsb_res_rob_pos = 4'(tbl[k].lt); lsb_res_val = 32'(tbl[k].lv);
            step();
            check($sformatf("tbl%0d_en", k), 32'(alu_en), 32'(tbl[k].e_en));
            check($sformatf("tbl%0d_val1", k), alu_val1, 32'(tbl[k].e_v1));
            check($sformatf("tbl%0d_val2", k), alu_val2, 32'(tbl[k].e_v2));
            check($sformatf("tbl%0d_full", k), 32'(rs_full), 32'(tbl[k].e_full));
        end

        // Fill all entries with pending ops, overflow once, then wake 4 and 2 together.
        idle(); rst = 1'b1; step();
        for (int i = 0; i < N; i++) begin
            idle(); set_issue(1'b1, 4'(i), 32'h0, 1'b0, 4'h0, 32'(100 + i), 4'(i)); step();
        end
        check("fill_full", 32'(rs_full), 32'h1);
        idle(); set_issue(1'b0, 4'h0, 32'd77, 1'b0, 4'h0, 32'd88, 4'hF); step();
        check("overflow_full", 32'(rs_full), 32'h1);
        check("overflow_en", 32'(alu_en), 32'h0);
        idle(); step();
        check("overflow_dropped", 32'(alu_en), 32'h0);
        idle();
        alu_res = 1'b1; alu_res_rob_pos = 4'd4; alu_res_val = 32'h40;
        lsb_res = 1'b1; lsb_res_rob_pos = 4'd2; lsb_res_val = 32'h20;
        step();
        check("wake_en", 32'(alu_en), 32'h0);
        idle(); step();
        check("first_en", 32'(alu_en), 32'h1);
        check("first_val1", alu_val1, 32'h20);
        check("first_val2", alu_val2, 32'd102);
        check("first_full", 32'(rs_full), 32'h0);
        idle(); step();
        check("second_en", 32'(alu_en), 32'h1);
        check("second_val1", alu_val1, 32'h40);
        check("second_val2", alu_val2, 32'd104);
        idle(); step();
        check("drain_en", 32'(alu_en), 32'h0);

        // Rollback with five pending entries while a dispatch is on the ALU port.
        idle(); rst = 1'b1; step();
        for (int i = 0; i < 5; i++) begin
            idle(); set_issue(1'b1, 4'(10 + i), 32'h0, 1'b0, 4'h0, 32'h0, 4'(10 + i)); step();
        end
        idle(); set_issue(1'b0, 4'h0, 32'd3, 1'b0, 4'h0, 32'd4, 4'd5); step();
        idle(); step();
        check("pre_rb_en", 32'(alu_en), 32'h1);
        idle(); rollback = 1'b1; step();
        check("rb_en", 32'(alu_en), 32'h0);
        check("rb_full", 32'(rs_full), 32'h0);
        check("rb_val1", alu_val1, 32'h0);
        idle();
        alu_res = 1'b1; alu_res_rob_pos = 4'd10; alu_res_val = 32'h1;
        lsb_res = 1'b1; lsb_res_rob_pos = 4'd11; lsb_res_val = 32'h2;
        step();
        idle(); step();
        check("post_rb_en", 32'(alu_en), 32'h0);

        // Broadcast seen only while frozen must not wake the op.
        idle(); rst = 1'b1; step();
        idle(); set_issue(1'b1, 4'd6, 32'h0, 1'b0, 4'h0, 32'h5, 4'd1); step();
        for (int i = 0; i < 3; i++) begin
            idle(); rdy = 1'b0;
            alu_res = 1'b1; alu_res_rob_pos = 4'd6; alu_res_val = 32'h55;
            step();
            check("frozen_en", 32'(alu_en), 32'h0);
        end
        for (int i = 0; i < 2; i++) begin
            idle(); step();
            check("unfrozen_en", 32'(alu_en), 32'h0);
        end
        idle(); alu_res = 1'b1; alu_res_rob_pos = 4'd6; alu_res_val = 32'h66; step();
        idle(); step();
        check("fresh_en", 32'(alu_en), 32'h1);
        check("fresh_val1", alu_val1, 32'h66);
        idle(); set_issue(1'b0, 4'h0, 32'd9, 1'b0, 4'h0, 32'd1, 4'd2); step();
        idle(); step();
        for (int i = 0; i < 2; i++) begin
            idle(); rdy = 1'b0; step();
            check("hold_en", 32'(alu_en), 32'h1);
            check("hold_val1", alu_val1, 32'd9);
        end
        idle(); step();
        check("release_en", 32'(alu_en), 32'h0);

        // Randomized traffic against the model.
        idle(); rst = 1'b1; step();
        for (int c = 0; c < 3000; c++) begin
            idle();
            rst = ($urandom_range(0, 299) == 0);
            rollback = ($urandom_range(0, 59) == 0);
            rdy = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 1) == 1)
                set_issue(1'($urandom_range(0, 1)), 4'($urandom), $urandom,
                          1'($urandom_range(0, 1)), 4'($urandom), $urandom, 4'($urandom));
            alu_res = ($urandom_range(0, 9) < 4);
            alu_res_rob_pos = 4'($urandom); alu_res_val = $urandom;
            lsb_res = ($urandom_range(0, 9) < 4);
            lsb_res_rob_pos = 4'($urandom); lsb_res_val = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
